fdiv_frac_ctrl: RTL and testbench

- Run-time controller and sequencer for the fractional (N.5) clock divider path.
- Generates the divided output `clk_div` from `clk` using a dual-modulus period schedule.
- Accepts new divide ratios over a valid/ready config port.
- Switches ratio, starts and stops only on period boundaries, so `clk_div` never has a runt pulse.

---
 rtl/fdiv_frac_ctrl.sv | 79 +++++++
 tb/tb_fdiv_frac_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_frac_ctrl.sv
// fdiv_frac_ctrl: run-time sequencer for the N.5 fractional clock divider with boundary-safe reconfiguration
module fdiv_frac_ctrl #(
    parameter int   CNT_W    = 8,
    parameter int   DEF_INT  = 9,
    parameter logic DEF_HALF = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_int,
    input  logic             cfg_half,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_int,
    output logic             cur_half
);
    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, per, pend_int, pend_int_nx, cur_int_nx;
    logic pend_v, pend_v_nx, pend_half, pend_half_nx, cur_half_nx;
    logic last, start, fire, cfg_ok, apply, take;

    // period bookkeeping, next phase and config arbitration; ratio changes only at period starts
    always_comb begin
        per          = cur_int + CNT_W'(state == RUN_B);
        last         = state != IDLE && cnt == per - 1'b1;
        start        = state == IDLE || last;
        fire         = cfg_valid && cfg_ready;
        cfg_ok       = cfg_int >= CNT_W'(2) && !(cfg_half && &cfg_int);
        take         = fire && cfg_ok;
        apply        = pend_v && start;
        state_nx     = state;
        if (state == IDLE)
            state_nx = en ? RUN_A : IDLE;
        else if (last)
            state_nx = !en ? IDLE : (!pend_v && cur_half && state == RUN_A) ? RUN_B : RUN_A;
        cnt_nx       = start ? '0 : cnt + 1'b1;
        cur_int_nx   = apply ? pend_int  : (take && state == IDLE) ? cfg_int  : cur_int;
        cur_half_nx  = apply ? pend_half : (take && state == IDLE) ? cfg_half : cur_half;
        pend_v_nx    = (take && state != IDLE) || (pend_v && !apply);
        pend_int_nx  = take ? cfg_int  : pend_int;
        pend_half_nx = take ? cfg_half : pend_half;
    end

    // state and registered outputs; the first cycle of every period is high because every legal P is at least 2
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            clk_div   <= 1'b0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            pend_v    <= 1'b0;
            pend_int  <= '0;
            pend_half <= 1'b0;
            cur_int   <= CNT_W'(DEF_INT);
            cur_half  <= DEF_HALF;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            clk_div   <= state_nx != IDLE && cnt_nx < (per >> 1);
            tick      <= start && state_nx != IDLE;
            busy      <= state_nx != IDLE;
            cfg_ready <= !pend_v_nx;
            cfg_err   <= fire && !cfg_ok;
            pend_v    <= pend_v_nx;
            pend_int  <= pend_int_nx;
            pend_half <= pend_half_nx;
            cur_int   <= cur_int_nx;
            cur_half  <= cur_half_nx;
        end
    end
endmodule

// File: tb/tb_fdiv_frac_ctrl.sv
// tb_fdiv_frac_ctrl: directed and random checks of fdiv_frac_ctrl against a period-level reference model
module tb_fdiv_frac_ctrl;
    localparam int CNT_W = 8;
    logic clk = 1'b0, clr = 1'b0, en = 1'b0, cfg_valid = 1'b0, cfg_half = 1'b0;
    logic [CNT_W-1:0] cfg_int = '0;
    logic cfg_ready, cfg_err, clk_div, tick, busy, cur_half;
    logic [CNT_W-1:0] cur_int;
    int checks = 0, errors = 0;
    int n, hi, t_cnt;

    bit m_run, m_b, m_pv, m_half, m_phalf, m_err, m_ready, m_fire;
    int m_pos, m_int, m_pint;

    always #5 clk = ~clk;

    fdiv_frac_ctrl #(.CNT_W(CNT_W), .DEF_INT(9), .DEF_HALF(1'b1)) dut (
        .clk(clk), .clr(clr), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_int(cfg_int), .cfg_half(cfg_half), .cfg_err(cfg_err), .clk_div(clk_div),
        .tick(tick), .busy(busy), .cur_int(cur_int), .cur_half(cur_half)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_b = 0; m_pos = 0; m_int = 9; m_half = 1;
        m_pv = 0; m_err = 0; m_ready = 1; m_fire = 0;
    endtask

    // one rising edge of the reference: periods of N or N+1 cycles, config swapped only at a period start
    task automatic model_edge();
        bit was_run, ok;
        int plen;
        was_run = m_run;
        plen = m_int + int'(m_b);
        m_fire = cfg_valid && m_ready;
        ok = cfg_int >= 2 && !(cfg_half && cfg_int == 8'hff);
        if (!m_run) begin
            if (m_pv) begin m_int = m_pint; m_half = m_phalf; m_pv = 0; end
            if (en) begin m_run = 1; m_b = 0; m_pos = 0; end
        end else if (m_pos == plen - 1) begin
            m_pos = 0;
            if (m_pv) begin m_int = m_pint; m_half = m_phalf; m_pv = 0; m_b = 0; end
            else m_b = m_half ? !m_b : 1'b0;
            if (!en) m_run = 0;
        end else m_pos++;
        m_err = m_fire && !ok;
        if (m_fire && ok) begin
            if (was_run) begin m_pv = 1; m_pint = cfg_int; m_phalf = cfg_half; end
            else begin m_int = cfg_int; m_half = cfg_half; end
        end
        m_ready = !m_pv;
    endtask

    task automatic check_all(input string t);
        int plen;
        plen = m_int + int'(m_b);
        chk({t, ".clk_div"}, clk_div, m_run && m_pos < plen / 2);
        chk({t, ".tick"}, tick, m_run && m_pos == 0);
        chk({t, ".busy"}, busy, m_run);
        chk({t, ".cfg_ready"}, cfg_ready, m_ready);
        chk({t, ".cfg_err"}, cfg_err, m_err);
        chk({t, ".cur_int"}, cur_int, m_int);
        chk({t, ".cur_half"}, cur_half, m_half);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 0;
        #1 model_reset();
        check_all("rst");
        #1 clr = 1;
    endtask

    task automatic wait_at(input bit b, input int pos);
        int i;
        i = 0;
        while (!(m_run && m_b == b && m_pos == pos) && i < 300) begin step(); i++; end
        if (i == 300) chk("wait_timeout", 0, 1);
    endtask

    // steps until the next tick; hi counts high cycles of the period that was running when called, minus its first
    task automatic run_until_tick(output int cyc, output int h);
        cyc = 0; h = 0;
        do begin
            step();
            cyc++;
            if (clk_div === 1'b1 && tick !== 1'b1) h++;
        end while (tick !== 1'b1 && cyc < 300);
        if (cyc >= 300) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        model_reset();
        #12 check_all("rst0");
        #1 clr = 1;
        en = 1;
        t_cnt = 0;
        for (int i = 0; i < 38; i++) begin step(); if (tick === 1'b1) t_cnt++; end
        chk("ticks38", t_cnt, 4);
        run_until_tick(n, hi);
        chk("def.tail", n, 1);
        run_until_tick(n, hi);
        chk("def.pA", n, 9);
        chk("def.hiA", hi + 1, 4);
        run_until_tick(n, hi);
        chk("def.pB", n, 10);
        chk("def.hiB", hi + 1, 5);

        wait_at(0, 3);
        cfg_valid = 1; cfg_int = 4; cfg_half = 0;
        step();
        cfg_valid = 0;
        chk("rcfg.ready_low", cfg_ready, 0);
        run_until_tick(n, hi);
        chk("rcfg.rest", n, 5);
        chk("rcfg.ready_back", cfg_ready, 1);
        chk("rcfg.cur", cur_int, 4);
        for (int k = 0; k < 2; k++) begin
            run_until_tick(n, hi);
            chk("rcfg.p4", n, 4);
            chk("rcfg.hi", hi + 1, 2);
        end

        do_reset();
        en = 1;
        wait_at(0, 3);
        cfg_valid = 1; cfg_int = 1; cfg_half = 0;
        step();
        cfg_valid = 0;
        chk("ill1.err", cfg_err, 1);
        chk("ill1.cur", cur_int, 9);
        step();
        chk("ill1.err_off", cfg_err, 0);
        cfg_valid = 1; cfg_int = 8'hff; cfg_half = 1;
        step();
        cfg_valid = 0;
        chk("ill255.err", cfg_err, 1);
        chk("ill255.ready", cfg_ready, 1);
        step();
        chk("ill255.err_off", cfg_err, 0);
        chk("ill255.cur", cur_int, 9);

        wait_at(1, 2);
        en = 0;
        n = 0;
        do begin step(); n++; end while (busy !== 1'b0 && n < 50);
        chk("stop.cycles", n, 8);
        chk("stop.div", clk_div, 0);
        repeat (3) step();
        en = 1;
        step();
        chk("restart.tick", tick, 1);
        chk("restart.div", clk_div, 1);

        wait_at(0, 1);
        #1 clr = 0;
        #1 chk("ar.div", clk_div, 0);
        chk("ar.busy", busy, 0);
        model_reset();
        #9 clr = 1;
        step();
        chk("ar.tick", tick, 1);
        run_until_tick(n, hi);
        chk("ar.pA", n, 9);
        run_until_tick(n, hi);
        chk("ar.pB", n, 10);

        do_reset();
        en = 1;
        wait_at(0, 8);
        cfg_valid = 1; cfg_int = 3; cfg_half = 1;
        step();
        cfg_valid = 0;
        chk("bnd.tick", tick, 1);
        chk("bnd.cur_old", cur_int, 9);
        run_until_tick(n, hi);
        chk("bnd.old_p", n, 10);
        run_until_tick(n, hi);
        chk("bnd.p3", n, 3);
        chk("bnd.hi3", hi + 1, 1);
        run_until_tick(n, hi);
        chk("bnd.p4", n, 4);
        chk("bnd.hi4", hi + 1, 2);
        run_until_tick(n, hi);
        chk("bnd.p3b", n, 3);

        for (int i = 0; i < 3000; i++) begin
            step();
            if (cfg_valid && m_fire) cfg_valid = 0;
            else if (!cfg_valid && $urandom_range(0, 9) == 0) begin
                cfg_valid = 1;
                cfg_int = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom_range(0, 12));
                cfg_half = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 24) == 0) en = !en;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
